dmem_responder: RTL and testbench

- Responder (memory-side) end of the data-memory request bus. The pipeline datapath is the initiator.
- Accepts one word read or write request at a time, holds it for a programmable access latency, then returns a single-cycle response.
- Lets the pipeline be exercised against a non-zero-latency memory model instead of a combinational array.
- Sits on the mother board between the cpu's data-memory bus and the backing storage.

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_array.sv | 63 ++++++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared types and constants for the data-memory responder slice.
//   state_e : responder FSM states (IDLE, WAIT, RESP)
//   LAT_W   : width of the access-latency down-counter
//   WORD_W  : data word width
//   ADDR_W  : request byte-address width
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x WORD_W storage with a synchronous write port and a registered read
// port. The read register holds its value until the next read is enabled.
// Only the read register is cleared by reset; the storage array is not.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset (clears rd_data only)
//   wr_en    : write strobe, commits wr_data to wr_idx on the clock edge
//   wr_idx   : word index for writes
//   wr_data  : write data
//   rd_en    : load rd_data from rd_idx on the clock edge
//   rd_idx   : word index for reads
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] rd_data_d;

    // Storage array: plain synchronous write, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Next read value: fetch when enabled, otherwise keep the last read so the
    // responder's read data stays stable across writes and idle cycles.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // Read register with reset to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the data-memory request bus. Accepts one word read or
// write, holds it for LATENCY cycles, then pulses resp_valid for one cycle.
// Optional feature macro: DMEM_RESPONDER_ALIGN_CHECK_EN
//   defined   : requests with req_addr[1:0] != 0 respond with resp_err=1,
//               do not write the array and do not update resp_rdata
//   undefined : resp_err is tied 0 and the low address bits are ignored
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we                : 1 = write, 0 = read
//   req_addr              : byte address (wraps modulo DEPTH words)
//   req_wdata             : write data
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : read data, held until the next completed read
//   resp_err              : misaligned-access flag qualified by resp_valid
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              mis_q, mis_d;

    logic              mis_in;
    logic [AW-1:0]     req_idx;
    logic              rd_en;
    logic [AW-1:0]     rd_idx;
    logic              wr_en;
    logic              unused_addr;

    assign req_idx     = req_addr[AW+1:2];
    assign unused_addr = ^{req_addr[ADDR_W-1:AW+2], req_addr[1:0]};

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    assign mis_in   = (req_addr[1:0] != 2'b00);
    assign resp_err = resp_valid && mis_q;
`else
    assign mis_in   = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Next-state and output logic. The read port is enabled on the edge that
    // enters RESP so resp_rdata is valid alongside resp_valid; with LATENCY=1
    // that edge is the acceptance edge, so the index comes straight from the
    // request. Writes commit on the edge that leaves RESP, and both the pulse
    // and the commit are suppressed while reset is high so an aborted
    // transaction leaves no trace.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        mis_d      = mis_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = idx_q;
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    mis_d   = mis_in;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        rd_en   = !req_we && !mis_in;
                        rd_idx  = req_idx;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = RESP;
                    rd_en   = !we_q && !mis_q;
                end
            end
            RESP: begin
                resp_valid = !reset;
                wr_en      = we_q && !mis_q && !reset;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and captured request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (resp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Instance 0 uses LATENCY=2, instance 1
// uses LATENCY=1. A table of write/read vectors runs on instance 0, followed
// by hand-written sequences for reset abort, request holding, misalignment
// (DMEM_RESPONDER_ALIGN_CHECK_EN aware) and back-to-back LATENCY=1 traffic.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    localparam logic ALIGN_EN = 1'b1;
`else
    localparam logic ALIGN_EN = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid_s;
    logic [1:0]  req_ready_s;
    logic [1:0]  req_we_s;
    logic [31:0] req_addr_s  [2];
    logic [31:0] req_wdata_s [2];
    logic [1:0]  resp_valid_s;
    logic [31:0] resp_rdata_s [2];
    logic [1:0]  resp_err_s;

    int          vecCount;
    int          missCount;
    logic [31:0] lastRead;
    vec_t        vecs [10];

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        busyOk;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_s[0]),
        .req_ready  (req_ready_s[0]),
        .req_we     (req_we_s[0]),
        .req_addr   (req_addr_s[0]),
        .req_wdata  (req_wdata_s[0]),
        .resp_valid (resp_valid_s[0]),
        .resp_rdata (resp_rdata_s[0]),
        .resp_err   (resp_err_s[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid_s[1]),
        .req_ready  (req_ready_s[1]),
        .req_we     (req_we_s[1]),
        .req_addr   (req_addr_s[1]),
        .req_wdata  (req_wdata_s[1]),
        .resp_valid (resp_valid_s[1]),
        .resp_rdata (resp_rdata_s[1]),
        .resp_err   (resp_err_s[1])
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence wedges despite its own cycle bounds.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one transaction on instance d. Waits (bounded) for req_ready,
    // presents the request, and counts cycles after acceptance until
    // resp_valid. When hold is set, req_valid stays high and the request
    // fields keep changing during the wait. lat = -1 means no response.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold,
                                 output int latOut, output logic [31:0] rdOut,
                                 output logic errOut, output logic busyOut);
        int budget;
        latOut  = -1;
        rdOut   = '0;
        errOut  = 1'b0;
        busyOut = 1'b1;
        @(negedge clk);
        budget = 0;
        while (!req_ready_s[d] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        req_valid_s[d] = 1'b1;
        req_we_s[d]    = we;
        req_addr_s[d]  = addr;
        req_wdata_s[d] = wdata;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (req_ready_s[d]) busyOut = 1'b0;
            if (hold) begin
                req_wdata_s[d] = ~wdata ^ 32'(n);
                req_addr_s[d]  = addr + 32'(4 * n);
                req_we_s[d]    = ~we;
            end else begin
                req_valid_s[d] = 1'b0;
            end
            if (resp_valid_s[d]) begin
                latOut = n;
                rdOut  = resp_rdata_s[d];
                errOut = resp_err_s[d];
                break;
            end
        end
        req_valid_s[d] = 1'b0;
        req_we_s[d]    = 1'b0;
    endtask

    initial begin
        vecCount    = 0;
        missCount   = 0;
        lastRead    = 32'h0;
        reset       = 1'b1;
        req_valid_s = '0;
        req_we_s    = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr_s[i]  = '0;
            req_wdata_s[i] = '0;
        end

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5};
        vecs[4] = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D};
        vecs[7] = '{1'b1, 32'h0000_0004, 32'h0123_4567, 32'h0};
        vecs[8] = '{1'b0, 32'hFFFF_FF04, 32'h0,         32'h0123_4567};
        vecs[9] = '{1'b1, 32'h0000_00FC, 32'h7777_0001, 32'h0};

        // Reset state on both instances while reset is held high.
        repeat (3) @(posedge clk);
        req_valid_s = 2'b11;
        @(negedge clk);
        checkOutput("rst_ready0", 32'(req_ready_s[0]), 32'h0);
        checkOutput("rst_ready1", 32'(req_ready_s[1]), 32'h0);
        checkOutput("rst_valid0", 32'(resp_valid_s[0]), 32'h0);
        checkOutput("rst_rdata0", resp_rdata_s[0], 32'h0);
        checkOutput("rst_err0", 32'(resp_err_s[0]), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid_ignored", 32'(resp_valid_s[0]), 32'h0);
        req_valid_s = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready0", 32'(req_ready_s[0]), 32'h1);
        checkOutput("post_rst_valid0", 32'(resp_valid_s[0]), 32'h0);

        // Table-driven transactions on the LATENCY=2 instance.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] expRd;
            applyStimulus(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, lat, rd, er, busyOk);
            expRd = vecs[i].we ? lastRead : vecs[i].exp_rdata;
            if (!vecs[i].we) lastRead = vecs[i].exp_rdata;
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            checkOutput($sformatf("v%0d_rdata", i), rd, expRd);
            checkOutput($sformatf("v%0d_err", i), 32'(er), 32'h0);
            checkOutput($sformatf("v%0d_busy", i), 32'(busyOk), 32'h1);
        end

        // Request fields change while the write waits; only the accepted data lands.
        applyStimulus(0, 1'b1, 32'h0000_000C, 32'h5A5A_0001, 1'b1, lat, rd, er, busyOk);
        checkOutput("hold_latency", 32'(lat), 32'd2);
        applyStimulus(0, 1'b0, 32'h0000_000C, 32'h0, 1'b0, lat, rd, er, busyOk);
        checkOutput("hold_rdata", rd, 32'h5A5A_0001);
        lastRead = 32'h5A5A_0001;

        // Reset during the WAIT cycle of a write aborts it with no response.
        begin
            int budget;
            logic sawResp;
            sawResp = 1'b0;
            @(negedge clk);
            budget = 0;
            while (!req_ready_s[0] && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            req_valid_s[0] = 1'b1;
            req_we_s[0]    = 1'b1;
            req_addr_s[0]  = 32'h0000_0008;
            req_wdata_s[0] = 32'h1234_5678;
            @(posedge clk);
            @(negedge clk);
            req_valid_s[0] = 1'b0;
            req_we_s[0]    = 1'b0;
            if (resp_valid_s[0]) sawResp = 1'b1;
            reset = 1'b1;
            @(negedge clk);
            if (resp_valid_s[0]) sawResp = 1'b1;
            reset = 1'b0;
            @(negedge clk);
            checkOutput("abort_ready_after_rst", 32'(req_ready_s[0]), 32'h1);
            for (int n = 0; n < 3; n++) begin
                if (resp_valid_s[0]) sawResp = 1'b1;
                @(negedge clk);
            end
            checkOutput("abort_no_resp", 32'(sawResp), 32'h0);
            lastRead = 32'h0;
        end
        applyStimulus(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, lat, rd, er, busyOk);
        checkOutput("abort_prior_value", rd, 32'hCAFE_F00D);
        lastRead = 32'hCAFE_F00D;

        // Misaligned write to 0x6 targets word 1 (holds 0x01234567).
        applyStimulus(0, 1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b0, lat, rd, er, busyOk);
        checkOutput("mis_latency", 32'(lat), 32'd2);
        checkOutput("mis_err", 32'(er), ALIGN_EN ? 32'h1 : 32'h0);
        checkOutput("mis_rdata_held", rd, lastRead);
        applyStimulus(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0, lat, rd, er, busyOk);
        checkOutput("mis_word1", rd, ALIGN_EN ? 32'h0123_4567 : 32'hFFFF_FFFF);
        checkOutput("mis_read_err", 32'(er), 32'h0);

        // LATENCY=1: write then read held back-to-back, one response every 2 cycles.
        begin
            int budget;
            @(negedge clk);
            budget = 0;
            while (!req_ready_s[1] && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            req_valid_s[1] = 1'b1;
            req_we_s[1]    = 1'b1;
            req_addr_s[1]  = 32'h0000_0004;
            req_wdata_s[1] = 32'h0000_0011;
            @(posedge clk);
            @(negedge clk);
            checkOutput("l1_wr_resp", 32'(resp_valid_s[1]), 32'h1);
            checkOutput("l1_resp_ready", 32'(req_ready_s[1]), 32'h0);
            req_we_s[1] = 1'b0;
            @(negedge clk);
            checkOutput("l1_gap_valid", 32'(resp_valid_s[1]), 32'h0);
            checkOutput("l1_gap_ready", 32'(req_ready_s[1]), 32'h1);
            @(negedge clk);
            checkOutput("l1_rd_resp", 32'(resp_valid_s[1]), 32'h1);
            checkOutput("l1_rd_data", resp_rdata_s[1], 32'h0000_0011);
            req_valid_s[1] = 1'b0;
            @(negedge clk);
            checkOutput("l1_idle_valid", 32'(resp_valid_s[1]), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
